// File: rtl/toy_mem_pkg.sv
// Shared types and defaults for the RISC_TOY single-port memory arbiter.
// Holds the owner encoding, the return-tag layout and the tag builder.
package toy_mem_pkg;

  localparam int TOY_AW      = 10;
  localparam int TOY_MAXWAIT = 3;
  localparam int STARVE_W    = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } own_e;

  typedef struct packed {
    logic vld;
    own_e own;
  } rtag_t;

  localparam rtag_t RTAG_IDLE = '{vld: 1'b0, own: OWN_I};

  // Writes complete in the grant cycle, so only read grants issue a tag.
  function automatic rtag_t make_tag(input logic ignt, input logic dgnt, input logic drw);
    rtag_t tag;
    tag.vld = ignt | (dgnt & ~drw);
    tag.own = (dgnt & ~ignt & ~drw) ? OWN_D : OWN_I;
    return tag;
  endfunction

endpackage

// File: rtl/toy_starve_ctr.sv
// Saturating count of consecutive cycles a pending fetch has been denied.
// at_max tells the arbiter to hand the port to fetch this cycle.
module toy_starve_ctr
  import toy_mem_pkg::*;
#(
  parameter int MAXWAIT = TOY_MAXWAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAXWAIT);
  localparam logic [STARVE_W-1:0] ONE_C = {{(STARVE_W-1){1'b0}}, 1'b1};

  logic [STARVE_W-1:0] cnt_r;

  // Denial counter: clear wins over increment, increment stops at MAXWAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {STARVE_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {STARVE_W{1'b0}};
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/toy_mem_arbiter.sv
// Shares one SRAM port between fetch and load/store with data priority,
// a fetch starvation bound, and tagged steering of 1-cycle read returns.
module toy_mem_arbiter
  import toy_mem_pkg::*;
#(
  parameter int AW      = TOY_AW,
  parameter int MAXWAIT = TOY_MAXWAIT
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IREQ,
  input  logic [29:0]   IADDR,
  output logic          IGNT,
  output logic [31:0]   INSTR,
  output logic          IVALID,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic          DGNT,
  output logic [31:0]   DRDATA,
  output logic          DVALID,
  output logic          MCSN,
  output logic          MWEN,
  output logic [AW-1:0] MA,
  output logic [31:0]   MDI,
  input  logic [31:0]   MDOUT
);

  logic          ignt_s;
  logic          dgnt_s;
  logic          at_max_s;
  logic          starve_inc_s;
  logic          starve_clr_s;
  logic          mcsn_s;
  logic          mwen_s;
  logic [AW-1:0] ma_s;
  logic          ivalid_s;
  logic          dvalid_s;
  rtag_t         rtag_r;
  logic [31:0]   ihold_r;
  logic [31:0]   dhold_r;
  logic          unused_addr_s;

  assign unused_addr_s = ^{IADDR[29:AW], DADDR[29:AW]};

  assign starve_inc_s = IREQ & ~ignt_s;
  assign starve_clr_s = ~IREQ | ignt_s;

  toy_starve_ctr #(
    .MAXWAIT(MAXWAIT)
  ) u_starve (
    .clk   (CLK),
    .rst_n (RSTN),
    .inc   (starve_inc_s),
    .clr   (starve_clr_s),
    .at_max(at_max_s)
  );

  // Fixed data priority; fetch wins a contended cycle once it has waited MAXWAIT.
  always_comb begin
    ignt_s = 1'b0;
    dgnt_s = 1'b0;
    if (RSTN) begin
      case ({IREQ, DREQ})
        2'b01: dgnt_s = 1'b1;
        2'b10: ignt_s = 1'b1;
        2'b11: begin
          if (at_max_s) begin
            ignt_s = 1'b1;
          end else begin
            dgnt_s = 1'b1;
          end
        end
        default: begin
          ignt_s = 1'b0;
          dgnt_s = 1'b0;
        end
      endcase
    end else begin
      ignt_s = 1'b0;
      dgnt_s = 1'b0;
    end
  end

  // SRAM port drive; the address is forced to zero while reset masks requests.
  always_comb begin
    mcsn_s = ~(ignt_s | dgnt_s);
    mwen_s = ~(dgnt_s & DRW);
    ma_s   = {AW{1'b0}};
    if (!RSTN) begin
      ma_s = {AW{1'b0}};
    end else if (ignt_s) begin
      ma_s = IADDR[AW-1:0];
    end else begin
      ma_s = DADDR[AW-1:0];
    end
  end

  // One tag per cycle records who owns the word returning next cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rtag_r <= RTAG_IDLE;
    end else begin
      rtag_r <= make_tag(ignt_s, dgnt_s, DRW);
    end
  end

  assign ivalid_s = rtag_r.vld & (rtag_r.own == OWN_I);
  assign dvalid_s = rtag_r.vld & (rtag_r.own == OWN_D);

  // Keep each requester's last returned word so its output stays stable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ihold_r <= 32'h0000_0000;
      dhold_r <= 32'h0000_0000;
    end else begin
      ihold_r <= ivalid_s ? MDOUT : ihold_r;
      dhold_r <= dvalid_s ? MDOUT : dhold_r;
    end
  end

  assign IGNT   = ignt_s;
  assign DGNT   = dgnt_s;
  assign MCSN   = mcsn_s;
  assign MWEN   = mwen_s;
  assign MA     = ma_s;
  assign MDI    = DWDATA;
  assign IVALID = ivalid_s;
  assign DVALID = dvalid_s;
  assign INSTR  = ivalid_s ? MDOUT : ihold_r;
  assign DRDATA = dvalid_s ? MDOUT : dhold_r;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Self-checking bench for toy_mem_arbiter: directed scenarios plus a random
// run scored against a transaction-level model of grants, memory and returns.
module tb_toy_mem_arbiter;

  localparam int AW      = 10;
  localparam int MAXWAIT = 3;
  localparam int DEPTH   = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ireq;
  logic [29:0]   iaddr;
  logic          ignt;
  logic [31:0]   instr;
  logic          ivalid;
  logic          dreq;
  logic          drw;
  logic [29:0]   daddr;
  logic [31:0]   dwdata;
  logic          dgnt;
  logic [31:0]   drdata;
  logic          dvalid;
  logic          mcsn;
  logic          mwen;
  logic [AW-1:0] ma;
  logic [31:0]   mdi;
  logic [31:0]   mdout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toy_mem_arbiter #(.AW(AW), .MAXWAIT(MAXWAIT)) dut (
    .CLK(clk), .RSTN(rstn),
    .IREQ(ireq), .IADDR(iaddr), .IGNT(ignt), .INSTR(instr), .IVALID(ivalid),
    .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
    .DGNT(dgnt), .DRDATA(drdata), .DVALID(dvalid),
    .MCSN(mcsn), .MWEN(mwen), .MA(ma), .MDI(mdi), .MDOUT(mdout)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // SRAM: 1-cycle read latency, contents seeded until mem_init rises.
  logic        mem_init;
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= seed_word(i);
    end else if (!mcsn) begin
      if (!mwen) sram[ma] <= mdi;
      else       mdout    <= sram[ma];
    end
  end

  // Reference model state (transaction level).
  logic [31:0] shadow [DEPTH];
  int          denied;
  bit          pend_vld, pend_own;
  logic [31:0] pend_data, last_i, last_d;
  bit          e_ignt, e_dgnt, e_mcsn, e_mwen, e_ivalid, e_dvalid;
  logic [AW-1:0] e_ma;
  logic [31:0] e_instr, e_drdata;

  task automatic model_reset();
    denied = 0; pend_vld = 0; pend_own = 0; pend_data = 32'h0;
    last_i = 32'h0; last_d = 32'h0;
  endtask

  task automatic predict();
    e_ignt   = ireq && (!dreq || denied >= MAXWAIT);
    e_dgnt   = dreq && !e_ignt;
    e_mcsn   = !(e_ignt || e_dgnt);
    e_mwen   = !(e_dgnt && drw);
    e_ma     = e_ignt ? iaddr[AW-1:0] : daddr[AW-1:0];
    e_ivalid = pend_vld && !pend_own;
    e_dvalid = pend_vld && pend_own;
    e_instr  = e_ivalid ? pend_data : last_i;
    e_drdata = e_dvalid ? pend_data : last_d;
  endtask

  task automatic commit();
    if (e_ivalid) last_i = pend_data;
    if (e_dvalid) last_d = pend_data;
    if (e_ignt) begin
      pend_vld = 1; pend_own = 0; pend_data = shadow[iaddr[AW-1:0]];
    end else if (e_dgnt && !drw) begin
      pend_vld = 1; pend_own = 1; pend_data = shadow[daddr[AW-1:0]];
    end else begin
      pend_vld = 0;
    end
    if (e_dgnt && drw) shadow[daddr[AW-1:0]] = dwdata;
    if (ireq && !e_ignt) denied = (denied < MAXWAIT) ? denied + 1 : MAXWAIT;
    else                 denied = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    predict();
  endtask

  task automatic advance();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit ir, input logic [29:0] ia, input bit dr, input bit w,
                         input logic [29:0] da, input logic [31:0] wd);
    ireq = ir; iaddr = ia; dreq = dr; drw = w; daddr = da; dwdata = wd;
  endtask

  task automatic test_reset();
    set_req(1, 30'h3FF_0007, 1, 1, 30'h000_0123, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if ({ignt, dgnt, mcsn, mwen} !== 4'b0011) begin
      failures++; $display("FAIL reset_port got=%b exp=0011", {ignt, dgnt, mcsn, mwen});
    end
    checks++;
    if (ma !== {AW{1'b0}}) begin
      failures++; $display("FAIL reset_ma got=%h exp=0", ma);
    end
    checks++;
    if ({ivalid, dvalid} !== 2'b00 || instr !== 32'h0 || drdata !== 32'h0) begin
      failures++; $display("FAIL reset_out valid=%b instr=%h drdata=%h exp 00/0/0", {ivalid, dvalid}, instr, drdata);
    end
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    @(posedge clk); #1;
    mem_init = 1'b1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch();
    set_req(0, 30'h0, 1, 1, 30'h5, 32'hA5A5_0001);
    settle();
    checks++;
    if ({dgnt, mwen} !== 2'b10) begin
      failures++; $display("FAIL preload_write dgnt_mwen got=%b exp=10", {dgnt, mwen});
    end
    advance();
    set_req(1, 30'h5, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if ({ignt, mcsn} !== 2'b10 || ma !== 10'd5) begin
      failures++; $display("FAIL fetch_grant ignt_mcsn=%b ma=%h exp 10/5", {ignt, mcsn}, ma);
    end
    advance();
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if (ivalid !== 1'b1 || instr !== 32'hA5A5_0001) begin
      failures++; $display("FAIL fetch_return ivalid=%b instr=%h exp 1/a5a50001", ivalid, instr);
    end
    advance();
    settle();
    checks++;
    if (ivalid !== 1'b0 || instr !== 32'hA5A5_0001) begin
      failures++; $display("FAIL fetch_hold ivalid=%b instr=%h exp 0/a5a50001", ivalid, instr);
    end
    advance();
  endtask

  task automatic test_write_read();
    set_req(0, 30'h0, 1, 1, 30'h10, 32'hDEAD_BEEF);
    settle();
    checks++;
    if ({dgnt, mwen, mcsn} !== 3'b100 || mdi !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL write_cycle dgnt_mwen_mcsn=%b mdi=%h exp 100/deadbeef", {dgnt, mwen, mcsn}, mdi);
    end
    advance();
    set_req(0, 30'h0, 1, 0, 30'h10, 32'h0);
    settle();
    checks++;
    if (dvalid !== 1'b0 || mwen !== 1'b1 || dgnt !== 1'b1) begin
      failures++; $display("FAIL after_write dvalid=%b mwen=%b dgnt=%b exp 0/1/1", dvalid, mwen, dgnt);
    end
    advance();
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if (dvalid !== 1'b1 || drdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_back dvalid=%b drdata=%h exp 1/deadbeef", dvalid, drdata);
    end
    advance();
  endtask

  task automatic test_alternate();
    set_req(0, 30'h0, 1, 1, 30'h1, 32'h11); settle(); advance();
    set_req(0, 30'h0, 1, 1, 30'h2, 32'h22); settle(); advance();
    set_req(0, 30'h0, 1, 0, 30'h1, 32'h0);  settle(); advance();
    set_req(1, 30'h2, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if ({dvalid, ivalid} !== 2'b10 || drdata !== 32'h11 || ignt !== 1'b1) begin
      failures++; $display("FAIL alt_d dv_iv=%b drdata=%h ignt=%b exp 10/11/1", {dvalid, ivalid}, drdata, ignt);
    end
    advance();
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if ({dvalid, ivalid} !== 2'b01 || instr !== 32'h22 || drdata !== 32'h11) begin
      failures++; $display("FAIL alt_i dv_iv=%b instr=%h drdata=%h exp 01/22/11", {dvalid, ivalid}, instr, drdata);
    end
    advance();
  endtask

  task automatic test_idle();
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++;
      if (mcsn !== 1'b1 || {ivalid, dvalid} !== 2'b00 || instr !== 32'h22 || drdata !== 32'h11) begin
        failures++; $display("FAIL idle k=%0d mcsn=%b valid=%b instr=%h drdata=%h exp 1/00/22/11",
                             k, mcsn, {ivalid, dvalid}, instr, drdata);
      end
      advance();
    end
  endtask

  task automatic test_starve();
    bit prev_i = 0;
    set_req(1, 30'h2, 1, 0, 30'h1, 32'h0);
    for (int k = 0; k < 12; k++) begin
      bit want_i;
      want_i = ((k % (MAXWAIT + 1)) == MAXWAIT);
      settle();
      checks++;
      if ({ignt, dgnt} !== {want_i, !want_i}) begin
        failures++; $display("FAIL starve_grant k=%0d got=%b exp=%b", k, {ignt, dgnt}, {want_i, !want_i});
      end
      if (k > 0) begin
        checks++;
        if ({ivalid, dvalid} !== {prev_i, !prev_i} || (prev_i ? instr : drdata) !== (prev_i ? 32'h22 : 32'h11)) begin
          failures++; $display("FAIL starve_return k=%0d iv_dv=%b instr=%h drdata=%h exp_i=%b",
                               k, {ivalid, dvalid}, instr, drdata, prev_i);
        end
      end
      prev_i = want_i;
      advance();
    end
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if ({ivalid, dvalid} !== 2'b10 || instr !== 32'h22) begin
      failures++; $display("FAIL starve_last iv_dv=%b instr=%h exp 10/22", {ivalid, dvalid}, instr);
    end
    advance();
  endtask

  task automatic test_reset_mid_read();
    set_req(1, 30'h5, 0, 0, 30'h0, 32'h0);
    settle();
    checks++;
    if (ignt !== 1'b1) begin
      failures++; $display("FAIL midrst_grant ignt=%b exp 1", ignt);
    end
    #1;
    rstn = 1'b0;
    set_req(1, 30'h5, 1, 0, 30'h7, 32'h0);
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({mcsn, ignt, dgnt, ivalid, dvalid} !== 5'b10000 || instr !== 32'h0 || drdata !== 32'h0) begin
      failures++; $display("FAIL midrst_in_reset mcsn_ig_dg_iv_dv=%b instr=%h drdata=%h exp 10000/0/0",
                           {mcsn, ignt, dgnt, ivalid, dvalid}, instr, drdata);
    end
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    settle();
    checks++;
    if ({ivalid, dvalid} !== 2'b00 || instr !== 32'h0 || drdata !== 32'h0) begin
      failures++; $display("FAIL midrst_after valid=%b instr=%h drdata=%h exp 00/0/0", {ivalid, dvalid}, instr, drdata);
    end
    advance();
  endtask

  task automatic test_random();
    bit i_done = 1, d_done = 1;
    for (int n = 0; n < 400; n++) begin
      if (i_done) begin
        ireq  = ($urandom_range(0, 3) != 0);
        iaddr = {20'($urandom), 10'($urandom_range(0, 31))};
      end
      if (d_done) begin
        dreq   = ($urandom_range(0, 2) != 0);
        drw    = 1'($urandom_range(0, 1));
        daddr  = {20'($urandom), 10'($urandom_range(0, 31))};
        dwdata = $urandom;
      end
      settle();
      checks++;
      if ({ignt, dgnt, mcsn, mwen} !== {e_ignt, e_dgnt, e_mcsn, e_mwen} || ma !== e_ma) begin
        failures++; $display("FAIL rnd_port n=%0d ig_dg_cs_we=%b ma=%h exp %b/%h",
                             n, {ignt, dgnt, mcsn, mwen}, ma, {e_ignt, e_dgnt, e_mcsn, e_mwen}, e_ma);
      end
      checks++;
      if ({ivalid, dvalid} !== {e_ivalid, e_dvalid} || instr !== e_instr || drdata !== e_drdata) begin
        failures++; $display("FAIL rnd_return n=%0d iv_dv=%b instr=%h drdata=%h exp %b/%h/%h",
                             n, {ivalid, dvalid}, instr, drdata, {e_ivalid, e_dvalid}, e_instr, e_drdata);
      end
      i_done = !ireq || e_ignt;
      d_done = !dreq || e_dgnt;
      advance();
    end
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    settle();
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    mem_init = 1'b0;
    set_req(0, 30'h0, 0, 0, 30'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) shadow[i] = seed_word(i);
    model_reset();
    test_reset();
    test_fetch();
    test_write_read();
    test_alternate();
    test_idle();
    test_starve();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
